i2c_target_sync: RTL and testbench

Clocked I2C target (slave) that is the responding end of the team's I2C master. SCL and SDA are oversampled on the system clock, START/STOP are detected, a 7-bit address plus R/W is matched against a parameter, and the block ACKs and either accepts write bytes or returns read bytes. Multi-byte transfers are supported. It replaces the unclocked slave model in system-level benches and goes on-chip as the register-port front end.

---
 rtl/i2c_target_sync.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_target_sync.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_sync.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// unlimited-length writes and reads, open-drain SDA drive.
module i2c_target_sync #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] data_write_slave,
  output logic [7:0] data_read_slave,
  output logic       wr_valid,
  output logic       rd_load,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t     state, state_next;
  logic       scl_meta, scl_sync, scl_prev;
  logic       sda_meta, sda_sync, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] tx_reg, tx_next;
  logic       rw_bit, rw_next;
  logic       sda_low, sda_low_next;
  logic [7:0] rdata_next;
  logic       wr_valid_next, rd_load_next, busy_next;

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so reset release creates no events
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    rw_next       = rw_bit;
    sda_low_next  = sda_low;
    rdata_next    = data_read_slave;
    wr_valid_next = 1'b0;
    rd_load_next  = 1'b0;
    busy_next     = busy;
    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      sda_low_next = 1'b0;
      busy_next    = 1'b1;
    end else if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = 4'd0;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_STOP: sda_low_next = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            shift_next = {shift_reg[6:0], sda_sync};
            if (bit_cnt == 4'd7) begin
              bit_cnt_next = 4'd0;
              rw_next      = sda_sync;
              state_next   = (shift_reg[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            end else begin
              bit_cnt_next = bit_cnt + 4'd1;
            end
          end
        end
        // bit_cnt==0: ACK not yet driven; afterwards the next fall ends the ACK slot
        ADDR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_low_next = 1'b1;
              bit_cnt_next = 4'd1;
            end else if (rw_bit) begin
              tx_next      = {data_write_slave[6:0], 1'b0};
              rd_load_next = 1'b1;
              sda_low_next = ~data_write_slave[7];
              bit_cnt_next = 4'd1;
              state_next   = RD_DATA;
            end else begin
              sda_low_next = 1'b0;
              bit_cnt_next = 4'd0;
              state_next   = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_sync};
            bit_cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            rdata_next    = shift_reg;
            wr_valid_next = 1'b1;
            sda_low_next  = 1'b1;
            bit_cnt_next  = 4'd0;
            state_next    = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_low_next = 1'b0;
            state_next   = WR_DATA;
          end
        end
        // bit_cnt counts bits already placed on the bus
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low_next = 1'b0;
              bit_cnt_next = 4'd0;
              state_next   = RD_ACK;
            end else begin
              sda_low_next = ~tx_reg[7];
              tx_next      = {tx_reg[6:0], 1'b0};
              bit_cnt_next = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_sync) state_next = WAIT_STOP;
            else bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            tx_next      = {data_write_slave[6:0], 1'b0};
            rd_load_next = 1'b1;
            sda_low_next = ~data_write_slave[7];
            bit_cnt_next = 4'd1;
            state_next   = RD_DATA;
          end
        end
        default: begin
          state_next   = IDLE;
          sda_low_next = 1'b0;
        end
      endcase
    end
  end

  // rd_load marks the cycle whose closing edge captures data_write_slave
  assign rd_load = rd_load_next & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= 4'd0;
      shift_reg       <= 8'h00;
      tx_reg          <= 8'h00;
      rw_bit          <= 1'b0;
      sda_low         <= 1'b0;
      data_read_slave <= 8'h00;
      wr_valid        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_next;
      bit_cnt         <= bit_cnt_next;
      shift_reg       <= shift_next;
      tx_reg          <= tx_next;
      rw_bit          <= rw_next;
      sda_low         <= sda_low_next;
      data_read_slave <= rdata_next;
      wr_valid        <= wr_valid_next;
      busy            <= busy_next;
    end
  end

endmodule

// File: tb/tb_i2c_target_sync.sv
// Bus-level bench for i2c_target_sync: a behavioural I2C master drives directed
// and random transfers; expectations come from the addressing and transfer rules.
module tb_i2c_target_sync;
  localparam logic [6:0] SLAVE_ADDR = 7'b1010101;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       master_low;
  logic [7:0] data_write_slave;
  logic [7:0] data_read_slave;
  logic       wr_valid, rd_load, busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = master_low ? 1'b0 : 1'bz;

  i2c_target_sync #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
    .sda(sda_bus),
    .data_write_slave(data_write_slave),
    .data_read_slave(data_read_slave),
    .wr_valid(wr_valid),
    .rd_load(rd_load),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int lo_clk = 10;
  int hi_clk = 10;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int drive_viol = 0;
  int snap_wr, snap_rd, snap_viol;
  bit watch_release = 1'b0;
  bit arm_watch = 1'b0;
  logic [7:0] model_last_wr = 8'h00;
  logic [7:0] tx_data [16];
  logic [7:0] rx_data [16];
  bit         data_ack [16];
  bit         addr_ack;

  // Pulse counters and a watch for the target pulling sda while it should not
  always @(posedge clk) begin
    if (wr_valid) wr_pulses <= wr_pulses + 1;
    if (rd_load) rd_pulses <= rd_pulses + 1;
    if (watch_release && sda_bus === 1'b0 && !master_low) drive_viol <= drive_viol + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input bit b, output bit s);
    wait_clk(1);
    master_low = ~b;
    wait_clk(lo_clk - 1);
    scl = 1'b1;
    if (arm_watch) watch_release = 1'b1;
    wait_clk(hi_clk / 2);
    s = (sda_bus !== 1'b0);
    wait_clk(hi_clk - hi_clk / 2);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wait_clk(1);
      master_low = 1'b0;
      wait_clk(lo_clk - 1);
      scl = 1'b1;
      wait_clk(hi_clk);
    end
    master_low = 1'b1;
    wait_clk(hi_clk);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(1);
    master_low = 1'b1;
    wait_clk(lo_clk - 1);
    scl = 1'b1;
    wait_clk(hi_clk);
    master_low = 1'b0;
    wait_clk(hi_clk);
  endtask

  task automatic bus_write_byte(input logic [7:0] v, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic bus_read_bits(output logic [7:0] v);
    bit s;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      v = {v[6:0], s};
    end
  endtask

  // One complete transfer: START, address, n data bytes, optional STOP
  task automatic applyStimulus(input logic [6:0] addr, input bit rw, input int n, input bit end_stop);
    bit s;
    logic [7:0] v;
    snap_wr = wr_pulses;
    snap_rd = rd_pulses;
    snap_viol = drive_viol;
    watch_release = (addr != SLAVE_ADDR);
    if (rw) data_write_slave = tx_data[0];
    bus_start();
    bus_write_byte({addr, rw}, addr_ack);
    checkOutput("busy_active", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        bus_write_byte(tx_data[i], data_ack[i]);
      end else begin
        bus_read_bits(v);
        rx_data[i] = v;
        if (i + 1 < n) data_write_slave = tx_data[i + 1];
        else arm_watch = 1'b1;
        bus_bit(i + 1 == n, s);
      end
    end
    if (end_stop) begin
      bus_stop();
      wait_clk(4);
      checkOutput("busy_idle", 32'(busy), 32'd0);
    end
    watch_release = 1'b0;
    arm_watch = 1'b0;
  endtask

  // Reference: only SLAVE_ADDR is acknowledged; acknowledged writes update the
  // register once per byte, acknowledged reads return the supplied bytes in order
  task automatic checkTransfer(input logic [6:0] addr, input bit rw, input int n);
    bit hit;
    hit = (addr == SLAVE_ADDR);
    checkOutput("addr_ack", 32'(addr_ack), hit ? 32'd0 : 32'd1);
    if (!rw) begin
      for (int i = 0; i < n; i++) checkOutput("data_ack", 32'(data_ack[i]), hit ? 32'd0 : 32'd1);
      if (hit) model_last_wr = tx_data[n - 1];
      checkOutput("wr_pulses", 32'(wr_pulses - snap_wr), hit ? 32'(n) : 32'd0);
      checkOutput("rd_pulses_on_write", 32'(rd_pulses - snap_rd), 32'd0);
    end else begin
      for (int i = 0; i < n; i++) checkOutput("rx_byte", 32'(rx_data[i]), hit ? 32'(tx_data[i]) : 32'hFF);
      checkOutput("rd_pulses", 32'(rd_pulses - snap_rd), hit ? 32'(n) : 32'd0);
      checkOutput("wr_pulses_on_read", 32'(wr_pulses - snap_wr), 32'd0);
    end
    checkOutput("data_read_slave", 32'(data_read_slave), 32'(model_last_wr));
    checkOutput("sda_released", 32'(drive_viol - snap_viol), 32'd0);
  endtask

  initial begin
    bit s;
    bit rw;
    int n;
    logic [6:0] ra;

    rst = 1'b1;
    scl = 1'b1;
    master_low = 1'b0;
    data_write_slave = 8'h00;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    checkOutput("reset_data", 32'(data_read_slave), 32'h00);
    checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("reset_rd_load", 32'(rd_load), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_sda", 32'(sda_bus), 32'd1);

    $display("[TB] write 0xAA");
    tx_data[0] = 8'hAA;
    applyStimulus(SLAVE_ADDR, 1'b0, 1, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b0, 1);

    $display("[TB] read 0x29");
    tx_data[0] = 8'h29;
    applyStimulus(SLAVE_ADDR, 1'b1, 1, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b1, 1);

    $display("[TB] wrong address");
    tx_data[0] = 8'hFF;
    applyStimulus(7'h2A, 1'b0, 1, 1'b1);
    checkTransfer(7'h2A, 1'b0, 1);

    $display("[TB] multi-byte write, repeated START, multi-byte read");
    tx_data[0] = 8'h11;
    tx_data[1] = 8'h22;
    applyStimulus(SLAVE_ADDR, 1'b0, 2, 1'b0);
    checkTransfer(SLAVE_ADDR, 1'b0, 2);
    tx_data[0] = 8'h3C;
    tx_data[1] = 8'hC3;
    applyStimulus(SLAVE_ADDR, 1'b1, 2, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b1, 2);

    $display("[TB] reset during write ACK");
    bus_start();
    bus_write_byte({SLAVE_ADDR, 1'b0}, addr_ack);
    checkOutput("rst_addr_ack", 32'(addr_ack), 32'd0);
    for (int i = 7; i >= 0; i--) bus_bit(tx_data[1][i], s);
    wait_clk(1);
    master_low = 1'b0;
    wait_clk(3);
    checkOutput("rst_ack_low", 32'(sda_bus), 32'd0);
    checkOutput("rst_pre_data", 32'(data_read_slave), 32'hC3);
    rst = 1'b1;
    wait_clk(1);
    checkOutput("rst_sda_release", 32'(sda_bus), 32'd1);
    checkOutput("rst_data", 32'(data_read_slave), 32'h00);
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("rst_rd_load", 32'(rd_load), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    model_last_wr = 8'h00;
    scl = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    tx_data[0] = 8'h5A;
    applyStimulus(SLAVE_ADDR, 1'b0, 1, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b0, 1);

    $display("[TB] minimum SCL phases");
    lo_clk = 6;
    hi_clk = 6;
    tx_data[0] = 8'hAA;
    applyStimulus(SLAVE_ADDR, 1'b0, 1, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b0, 1);
    tx_data[0] = 8'h29;
    applyStimulus(SLAVE_ADDR, 1'b1, 1, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b1, 1);

    $display("[TB] STOP mid-byte");
    lo_clk = 10;
    hi_clk = 10;
    snap_wr = wr_pulses;
    bus_start();
    bus_write_byte({SLAVE_ADDR, 1'b0}, addr_ack);
    checkOutput("midstop_addr_ack", 32'(addr_ack), 32'd0);
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    bus_stop();
    wait_clk(4);
    checkOutput("midstop_busy", 32'(busy), 32'd0);
    checkOutput("midstop_wr_pulses", 32'(wr_pulses - snap_wr), 32'd0);
    checkOutput("midstop_data", 32'(data_read_slave), 32'(model_last_wr));
    tx_data[0] = 8'h96;
    applyStimulus(SLAVE_ADDR, 1'b0, 1, 1'b1);
    checkTransfer(SLAVE_ADDR, 1'b0, 1);

    $display("[TB] random transfers");
    for (int it = 0; it < 10; it++) begin
      lo_clk = $urandom_range(6, 10);
      hi_clk = $urandom_range(6, 10);
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      for (int i = 0; i < n; i++) tx_data[i] = 8'($urandom_range(0, 255));
      applyStimulus(ra, rw, n, 1'b1);
      checkTransfer(ra, rw, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
